instruction_decode: RTL and testbench
=====================================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter WIDTH, default 32, sets the data-path and register width.
REQ-002 Parameter SP_RESET, default 32'h0000_3FFC, sets the reset value of register $29.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 start_up  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 instruction  input  32  instruction word from instruction_fetch.
REQ-006 reg_write  input  1  write-enable for the register file, from main_control.
REQ-007 reg_dst  input  1  destination select: 1 = rd [15:11], 0 = rt [20:16].
REQ-008 ext_op  input  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
REQ-009 wb_data  input  WIDTH  write-back data from the datapath.
REQ-010 opcode  output  6  instruction[31:26], combinational.
REQ-011 funct  output  6  instruction[5:0], combinational.
REQ-012 shamt  output  5  instruction[10:6], combinational.
REQ-013 wr_addr  output  5  selected destination register index, combinational.
REQ-014 rs_data  output  WIDTH  register file read port A, addressed by instruction[25:21].
REQ-015 rt_data  output  WIDTH  register file read port B, addressed by instruction[20:16].
REQ-016 imm_ext  output  WIDTH  extended instruction[15:0].
REQ-017 instr_count  output  32  retired-instruction counter.

Function
REQ-018 Register file SHALL hold 32 registers of WIDTH bits.
REQ-019 Reads SHALL be combinational, with zero-cycle latency from instruction change.
REQ-020 When reg_write=1 and wr_addr!=0, reg[wr_addr] SHALL load wb_data at the rising clk edge.
REQ-021 Writes with wr_addr=0 SHALL be discarded; reading $0 SHALL always return 0.
REQ-022 Same-cycle read and write to one register: the read SHALL return the old value until the edge (no bypass); the new value is visible after the edge.
REQ-023 wr_addr SHALL equal instruction[15:11] when reg_dst=1, else instruction[20:16].
REQ-024 imm_ext SHALL be {{16{imm[15]}},imm} when ext_op=1 and {16'b0,imm} when ext_op=0.
REQ-025 instr_count SHALL increment by 1 on every rising clk edge while start_up=1.
REQ-026 instr_count SHALL wrap from 32'hFFFF_FFFF to 0 with no flag.
REQ-027 A write with reg_write=0 SHALL leave all registers unchanged regardless of wb_data.

Reset
REQ-028 start_up=0 SHALL asynchronously clear all registers except $29 to 0 and instr_count to 0.
REQ-029 start_up=0 SHALL asynchronously set $29 to SP_RESET.
REQ-030 A write coinciding with reset assertion SHALL be dropped; reset wins.
REQ-031 The first write and count SHALL occur on the first rising edge after start_up returns to 1.
REQ-032 Combinational outputs (opcode, funct, shamt, wr_addr, imm_ext) SHALL track instruction during reset; rs_data and rt_data SHALL show the reset register contents.

Structure
REQ-033 Shared package SHALL define the field bit positions (OP, RS, RT, RD, SHAMT, FUNCT, IMM), register index constants REG_ZERO=0 and REG_SP=29, and WIDTH.
REQ-034 One sub-module, register_file (2 read ports, 1 write port, async active-low reset), SHALL be instantiated; decode and extension logic SHALL stay in the top module.

Verification
REQ-035 Reset: start_up=0 mid-cycle -> all rs/rt reads 0 immediately, read of $29 = 32'h0000_3FFC, instr_count=0.
REQ-036 R-type write: instruction=32'h0109_5020 (add $10,$8,$9), reg_dst=1, reg_write=1, wb_data=32'hDEAD_BEEF -> wr_addr=10; after the edge a read of $10 = 32'hDEAD_BEEF.
REQ-037 $0 protection: reg_write=1, wr_addr=0, wb_data=32'hFFFF_FFFF -> read of $0 stays 0.
REQ-038 Extension: imm=16'h8001 -> imm_ext=32'hFFFF_8001 with ext_op=1, and 32'h0000_8001 with ext_op=0.
REQ-039 Read-during-write: $5=1, write 7 to $5 while reading $5 -> rs_data=1 before the edge, 7 after.
REQ-040 Counter wrap: force instr_count to 32'hFFFF_FFFF, one edge -> 0; assert start_up=0 together with a pending write -> the target register stays 0.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// Shared definitions for the instruction decode stage: instruction field
// positions, architectural register indices and the default data width.
package instruction_decode_pkg;

    localparam int unsigned WIDTH = 32;

    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;
    localparam int unsigned SHAMT_HI = 10;
    localparam int unsigned SHAMT_LO = 6;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports, one write port,
// $0 hard-wired to zero and $29 reset to the stack-pointer value.
module register_file
    import instruction_decode_pkg::*;
#(
    parameter int unsigned         WIDTH    = 32,
    parameter logic [WIDTH-1:0]    SP_RESET = WIDTH'(32'h0000_3FFC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  reg_idx_t         waddr,
    input  logic [WIDTH-1:0] wdata,
    input  reg_idx_t         raddr_a,
    input  reg_idx_t         raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (reg_idx_t'(i) == REG_SP) ? SP_RESET : '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // No write bypass: a same-cycle write only becomes visible after the edge.
    assign rdata_a = (raddr_a == REG_ZERO) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == REG_ZERO) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: splits the instruction into fields, selects the destination,
// extends the immediate, hosts the register file and a retired-instruction counter.
module instruction_decode #(
    parameter int unsigned      WIDTH    = instruction_decode_pkg::WIDTH,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(32'h0000_3FFC)
) (
    input  logic             clk,
    input  logic             start_up,
    input  logic [31:0]      instruction,
    input  logic             reg_write,
    input  logic             reg_dst,
    input  logic             ext_op,
    input  logic [WIDTH-1:0] wb_data,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       shamt,
    output logic [4:0]       wr_addr,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] imm_ext,
    output logic [31:0]      instr_count
);
    import instruction_decode_pkg::*;

    reg_idx_t    rs_idx;
    reg_idx_t    rt_idx;
    reg_idx_t    rd_idx;
    logic [15:0] imm;
    logic [31:0] count_q;

    assign opcode = instruction[OP_HI:OP_LO];
    assign funct  = instruction[FUNCT_HI:FUNCT_LO];
    assign shamt  = instruction[SHAMT_HI:SHAMT_LO];
    assign rs_idx = instruction[RS_HI:RS_LO];
    assign rt_idx = instruction[RT_HI:RT_LO];
    assign rd_idx = instruction[RD_HI:RD_LO];
    assign imm    = instruction[IMM_HI:IMM_LO];

    assign wr_addr = reg_dst ? rd_idx : rt_idx;

    always_comb begin
        imm_ext = {{(WIDTH-16){1'b0}}, imm};
        if (ext_op) begin
            imm_ext = {{(WIDTH-16){imm[15]}}, imm};
        end
    end

    register_file #(
        .WIDTH    (WIDTH),
        .SP_RESET (SP_RESET)
    ) u_register_file (
        .clk     (clk),
        .rst_n   (start_up),
        .we      (reg_write),
        .waddr   (wr_addr),
        .wdata   (wb_data),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    // Free-running; wraps silently at 2^32.
    always_ff @(posedge clk or negedge start_up) begin
        if (!start_up) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;

    logic        clk;
    logic        start_up;
    logic [31:0] instruction;
    logic        reg_write;
    logic        reg_dst;
    logic        ext_op;
    logic [31:0] wb_data;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  wr_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    instruction_decode dut (
        .clk         (clk),
        .start_up    (start_up),
        .instruction (instruction),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .ext_op      (ext_op),
        .wb_data     (wb_data),
        .opcode      (opcode),
        .funct       (funct),
        .shamt       (shamt),
        .wr_addr     (wr_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    // Write one register through the rd path and return to idle.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        instruction = rtype(5'd0, 5'd0, addr);
        reg_dst     = 1'b1;
        reg_write   = 1'b1;
        wb_data     = data;
        @(negedge clk);
        reg_write   = 1'b0;
    endtask

    task automatic test_reset;
        write_reg(5'd8, 32'h0000_1234);
        instruction = rtype(5'd8, 5'd29, 5'd0);
        #1;
        n_cmp++;
        if (rs_data !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL pre_reset_rs: got %h want %h", rs_data, 32'h0000_1234);
        end
        #1 start_up = 1'b0;
        #1;
        n_cmp++;
        if (rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rs_clear: got %h want %h", rs_data, 32'h0);
        end
        n_cmp++;
        if (rt_data !== 32'h0000_3FFC) begin
            n_err++;
            $display("FAIL reset_sp: got %h want %h", rt_data, 32'h0000_3FFC);
        end
        n_cmp++;
        if (instr_count !== 32'h0) begin
            n_err++;
            $display("FAIL reset_count: got %h want %h", instr_count, 32'h0);
        end
        // Field decode must keep tracking the instruction while in reset.
        instruction = 32'hFC00_07FF;
        reg_dst     = 1'b1;
        ext_op      = 1'b1;
        #1;
        n_cmp++;
        if ({opcode, funct, shamt, wr_addr} !== {6'h3F, 6'h3F, 5'h1F, 5'd0}) begin
            n_err++;
            $display("FAIL reset_fields: got %h/%h/%h/%h want 3f/3f/1f/00",
                     opcode, funct, shamt, wr_addr);
        end
        n_cmp++;
        if (imm_ext !== 32'h0000_07FF) begin
            n_err++;
            $display("FAIL reset_imm: got %h want %h", imm_ext, 32'h0000_07FF);
        end
        @(negedge clk);
        start_up = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd1) begin
            n_err++;
            $display("FAIL count_first_edge: got %h want %h", instr_count, 32'd1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd2) begin
            n_err++;
            $display("FAIL count_second_edge: got %h want %h", instr_count, 32'd2);
        end
    endtask

    task automatic test_rtype;
        @(negedge clk);
        instruction = 32'h0109_5020;
        reg_dst     = 1'b1;
        reg_write   = 1'b1;
        wb_data     = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({opcode, funct, wr_addr} !== {6'h00, 6'h20, 5'd10}) begin
            n_err++;
            $display("FAIL rtype_decode: got %h/%h/%0d want 00/20/10", opcode, funct, wr_addr);
        end
        reg_dst = 1'b0;
        #1;
        n_cmp++;
        if (wr_addr !== 5'd9) begin
            n_err++;
            $display("FAIL rtype_rt_dst: got %0d want 9", wr_addr);
        end
        reg_dst = 1'b1;
        @(negedge clk);
        reg_write   = 1'b0;
        instruction = rtype(5'd10, 5'd9, 5'd0);
        #1;
        n_cmp++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rtype_readback: got %h want %h", rs_data, 32'hDEAD_BEEF);
        end
        n_cmp++;
        if (rt_data !== 32'h0) begin
            n_err++;
            $display("FAIL rtype_rt_untouched: got %h want %h", rt_data, 32'h0);
        end
    endtask

    task automatic test_zero_reg;
        write_reg(5'd0, 32'hFFFF_FFFF);
        instruction = rtype(5'd0, 5'd0, 5'd0);
        #1;
        n_cmp++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg: got %h/%h want 0/0", rs_data, rt_data);
        end
    endtask

    task automatic test_extension;
        @(negedge clk);
        instruction = 32'h2001_8001;
        ext_op      = 1'b1;
        #1;
        n_cmp++;
        if (imm_ext !== 32'hFFFF_8001) begin
            n_err++;
            $display("FAIL sign_ext: got %h want %h", imm_ext, 32'hFFFF_8001);
        end
        ext_op = 1'b0;
        #1;
        n_cmp++;
        if (imm_ext !== 32'h0000_8001) begin
            n_err++;
            $display("FAIL zero_ext: got %h want %h", imm_ext, 32'h0000_8001);
        end
        instruction = 32'h2001_7FFF;
        ext_op      = 1'b1;
        #1;
        n_cmp++;
        if (imm_ext !== 32'h0000_7FFF) begin
            n_err++;
            $display("FAIL sign_ext_pos: got %h want %h", imm_ext, 32'h0000_7FFF);
        end
    endtask

    task automatic test_read_during_write;
        write_reg(5'd5, 32'd1);
        instruction = rtype(5'd5, 5'd0, 5'd5);
        reg_dst     = 1'b1;
        reg_write   = 1'b1;
        wb_data     = 32'd7;
        #1;
        n_cmp++;
        if (rs_data !== 32'd1) begin
            n_err++;
            $display("FAIL rdw_before_edge: got %h want %h", rs_data, 32'd1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rs_data !== 32'd7) begin
            n_err++;
            $display("FAIL rdw_after_edge: got %h want %h", rs_data, 32'd7);
        end
        reg_write = 1'b0;
        wb_data   = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rs_data !== 32'd7) begin
            n_err++;
            $display("FAIL no_write_enable: got %h want %h", rs_data, 32'd7);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            instruction = rtype(5'd0, 5'd0, 5'(i));
            wb_data     = 32'h1000_0000 + 32'(i);
            @(negedge clk);
        end
        reg_write   = 1'b0;
        instruction = rtype(5'd1, 5'd3, 5'd0);
        #1;
        n_cmp++;
        if (rs_data !== 32'h1000_0001 || rt_data !== 32'h1000_0003) begin
            n_err++;
            $display("FAIL b2b_1_3: got %h/%h want 10000001/10000003", rs_data, rt_data);
        end
        instruction = rtype(5'd2, 5'd29, 5'd0);
        #1;
        n_cmp++;
        if (rs_data !== 32'h1000_0002 || rt_data !== 32'h0000_3FFC) begin
            n_err++;
            $display("FAIL b2b_2_sp: got %h/%h want 10000002/00003ffc", rs_data, rt_data);
        end
    endtask

    task automatic test_wrap_and_reset_write;
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        n_cmp++;
        if (instr_count !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL count_preset: got %h want %h", instr_count, 32'hFFFF_FFFF);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'h0) begin
            n_err++;
            $display("FAIL count_wrap: got %h want %h", instr_count, 32'h0);
        end
        // Pending write to $12 held across an edge while reset is asserted.
        @(negedge clk);
        instruction = rtype(5'd12, 5'd0, 5'd12);
        reg_dst     = 1'b1;
        reg_write   = 1'b1;
        wb_data     = 32'h5555_5555;
        #2 start_up = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        start_up  = 1'b1;
        #1;
        n_cmp++;
        if (rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_drops_write: got %h want %h", rs_data, 32'h0);
        end
        n_cmp++;
        if (instr_count !== 32'h0) begin
            n_err++;
            $display("FAIL count_after_reset: got %h want %h", instr_count, 32'h0);
        end
    endtask

    initial begin
        start_up    = 1'b0;
        instruction = 32'h0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        ext_op      = 1'b0;
        wb_data     = 32'h0;
        repeat (2) @(negedge clk);
        start_up = 1'b1;

        test_reset();
        test_rtype();
        test_zero_reg();
        test_extension();
        test_read_during_write();
        test_back_to_back();
        test_wrap_and_reset_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
